// File: rtl/probe_capture.sv
// probe_capture: qualified probe-bus capture buffer with a pre-trigger window.
// Samples are written into a simple dual-port RAM around a configurable
// trigger. The captured window is read back by logical index, where index 0
// is the oldest sample and index PRE_TRIG is the trigger sample.
// Optional feature macro: PROBE_CAPTURE_TIMESTAMP_EN stores a 32-bit cycle
// timestamp with each sample. When it is undefined, rd_ts is tied to zero.
module probe_capture #(
   parameter int DATA_W   = 128,
   parameter int DEPTH    = 1024,
   parameter int PRE_TRIG = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     arm,
   input  logic                     abort,
   input  logic [DATA_W-1:0]        probe,
   input  logic                     probe_en,
   input  logic [1:0]               trig_mode,
   input  logic [DATA_W-1:0]        trig_mask,
   input  logic [DATA_W-1:0]        trig_value,
   input  logic                     trig_ext,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic [31:0]              rd_ts,
   output logic                     busy,
   output logic                     triggered,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_PRE     = CW'(PRE_TRIG);
   localparam logic [CW-1:0] C_POST    = CW'(DEPTH - PRE_TRIG);
   localparam logic [AW-1:0] C_PRE_OFS = AW'(PRE_TRIG);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_WAIT,
      S_POST,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     w_wr_ptr_nxt;
   logic [AW-1:0]     r_trig_ptr;
   logic [AW-1:0]     w_trig_ptr_nxt;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [CW-1:0]     w_cnt_inc;
   logic              r_prev_match;
   logic              w_prev_nxt;
   logic              r_busy;
   logic              w_busy_nxt;
   logic              r_triggered;
   logic              w_triggered_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic              w_we;
   logic              w_match;
   logic              w_trig;
   logic              w_accept;
   logic [AW-1:0]     w_rd_phys;

   logic [DATA_W-1:0] r_mem [DEPTH];

   assign busy      = r_busy;
   assign triggered = r_triggered;
   assign done      = r_done;

   assign w_match   = (((probe ^ trig_value) & trig_mask) == '0);
   assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) && arm && !abort;
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_rd_phys = r_trig_ptr - C_PRE_OFS + rd_addr;

   // Trigger decode by mode; only meaningful on qualified cycles.
   always_comb begin
      w_trig = 1'b0;
      case (trig_mode)
         2'b00:   w_trig = w_match;
         2'b01:   w_trig = w_match && !r_prev_match;
         2'b10:   w_trig = trig_ext;
         default: w_trig = 1'b1;
      endcase
   end

   // Next-state, pointer/counter update and RAM write enable.
   always_comb begin
      w_state_nxt     = r_state;
      w_wr_ptr_nxt    = r_wr_ptr;
      w_trig_ptr_nxt  = r_trig_ptr;
      w_cnt_nxt       = r_cnt;
      w_prev_nxt      = r_prev_match;
      w_triggered_nxt = r_triggered;
      w_done_nxt      = r_done;
      w_we            = 1'b0;

      if (r_busy && probe_en) begin
         w_prev_nxt = w_match;
      end

      case (r_state)
         S_IDLE, S_DONE: begin
            if (arm) begin
               w_wr_ptr_nxt    = '0;
               w_cnt_nxt       = '0;
               w_triggered_nxt = 1'b0;
               w_done_nxt      = 1'b0;
               w_prev_nxt      = 1'b1;
               // No pre-trigger window: skip straight to trigger search.
               w_state_nxt     = (PRE_TRIG == 0) ? S_WAIT : S_ARMED;
            end
         end
         S_ARMED: begin
            if (probe_en) begin
               w_we         = 1'b1;
               w_wr_ptr_nxt = r_wr_ptr + AW'(1);
               w_cnt_nxt    = w_cnt_inc;
               if (w_cnt_inc == C_PRE) begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (probe_en) begin
               w_we         = 1'b1;
               w_wr_ptr_nxt = r_wr_ptr + AW'(1);
               if (w_trig) begin
                  w_trig_ptr_nxt  = r_wr_ptr;
                  w_cnt_nxt       = CW'(1);
                  w_triggered_nxt = 1'b1;
                  if (C_POST == CW'(1)) begin
                     w_state_nxt = S_DONE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_POST;
                  end
               end
            end
         end
         S_POST: begin
            if (probe_en) begin
               w_we         = 1'b1;
               w_wr_ptr_nxt = r_wr_ptr + AW'(1);
               w_cnt_nxt    = w_cnt_inc;
               if (w_cnt_inc == C_POST) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Abort overrides everything, including a simultaneous arm.
      if (abort) begin
         w_state_nxt     = S_IDLE;
         w_done_nxt      = 1'b0;
         w_triggered_nxt = 1'b0;
         w_we            = 1'b0;
      end

      w_busy_nxt = (w_state_nxt == S_ARMED) || (w_state_nxt == S_WAIT) ||
                   (w_state_nxt == S_POST);
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_trig_ptr   <= '0;
         r_cnt        <= '0;
         r_prev_match <= 1'b0;
         r_busy       <= 1'b0;
         r_triggered  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_ptr     <= w_wr_ptr_nxt;
         r_trig_ptr   <= w_trig_ptr_nxt;
         r_cnt        <= w_cnt_nxt;
         r_prev_match <= w_prev_nxt;
         r_busy       <= w_busy_nxt;
         r_triggered  <= w_triggered_nxt;
         r_done       <= w_done_nxt;
      end
   end

   // Sample RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (rst_n && w_we) begin
         r_mem[r_wr_ptr] <= probe;
      end
   end

   // Sample RAM read port, logical index rotated to physical address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= r_mem[w_rd_phys];
      end
   end

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
   logic [31:0] r_ts;
   logic [31:0] r_ts_mem [DEPTH];

   // Free-running capture timestamp, restarted by an accepted arm.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ts <= '0;
      end else if (w_accept) begin
         r_ts <= '0;
      end else if (r_busy) begin
         r_ts <= r_ts + 32'd1;
      end
   end

   // Timestamp RAM write port, shadowing the sample RAM.
   always_ff @(posedge clk) begin
      if (rst_n && w_we) begin
         r_ts_mem[r_wr_ptr] <= r_ts;
      end
   end

   // Timestamp RAM read port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ts <= '0;
      end else begin
         rd_ts <= r_ts_mem[w_rd_phys];
      end
   end
`else
   logic w_unused_accept;
   assign w_unused_accept = w_accept;
   assign rd_ts           = '0;
`endif

endmodule

// File: tb/tb_probe_capture.sv
// Testbench for probe_capture (DATA_W=8, DEPTH=16, PRE_TRIG=4).
// Expected windows come from a list-based model: the qualified samples since
// arm are kept in order, the trigger is the first qualifying sample at list
// position >= PRE_TRIG, and the window is the PRE_TRIG samples before it plus
// DEPTH-PRE_TRIG samples from it onward.
module tb_probe_capture;

   localparam int DW = 8;
   localparam int DP = 16;
   localparam int PT = 4;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          arm;
   logic          abort;
   logic [DW-1:0] probe;
   logic          probe_en;
   logic [1:0]    trig_mode;
   logic [DW-1:0] trig_mask;
   logic [DW-1:0] trig_value;
   logic          trig_ext;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [31:0]   rd_ts;
   logic          busy;
   logic          triggered;
   logic          done;

   always #5 clk = ~clk;

   probe_capture #(
      .DATA_W  (DW),
      .DEPTH   (DP),
      .PRE_TRIG(PT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .arm       (arm),
      .abort     (abort),
      .probe     (probe),
      .probe_en  (probe_en),
      .trig_mode (trig_mode),
      .trig_mask (trig_mask),
      .trig_value(trig_value),
      .trig_ext  (trig_ext),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_ts     (rd_ts),
      .busy      (busy),
      .triggered (triggered),
      .done      (done)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] q_probe[$];
   logic       q_ext[$];
   int         q_cyc[$];
   logic [7:0] rd_buf[DP];

   typedef struct {
      string      nm;
      int         pk;
      int         ek;
      int         xk;
      logic [1:0] mode;
      logic [7:0] mask;
      logic [7:0] value;
      int         maxcyc;
      int         rearm;
      logic [7:0] e0;
      logic [7:0] e4;
      logic [7:0] e15;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gen_probe(input int pk, input int cyc);
      logic [7:0] v;
      case (pk)
         0:       v = cyc[7:0];
         1:       v = 8'($urandom);
         default: v = (cyc == 10) ? 8'h00 : 8'h55;
      endcase
      return v;
   endfunction

   function automatic logic gen_en(input int ek, input int cyc);
      case (ek)
         0:       return 1'b1;
         1:       return (cyc % 2) == 1;
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   function automatic logic gen_ext(input int xk, input int cyc);
      case (xk)
         0:       return 1'b0;
         1:       return cyc == 20;
         default: return $urandom_range(0, 15) == 0;
      endcase
   endfunction

   // First list position >= PT whose qualified sample fires the trigger.
   function automatic int model_trig(input logic [1:0] mode, input logic [7:0] mask,
                                     input logic [7:0] value);
      logic prev = 1'b1;
      logic m;
      logic t;
      for (int j = 0; j < q_probe.size(); j++) begin
         m = ((q_probe[j] ^ value) & mask) == 8'h00;
         case (mode)
            2'b00:   t = m;
            2'b01:   t = m && !prev;
            2'b10:   t = q_ext[j];
            default: t = 1'b1;
         endcase
         if (j >= PT && t) return j;
         prev = m;
      end
      return -1;
   endfunction

   task automatic capture(input string nm, input int pk, input int ek, input int xk,
                          input logic [1:0] mode, input logic [7:0] mask,
                          input logic [7:0] value, input int maxcyc, input int rearm,
                          output logic got_done);
      int ti;
      int exp_end;
      int base;
      logic seen = 1'b0;
      q_probe.delete();
      q_ext.delete();
      q_cyc.delete();
      trig_mode  = mode;
      trig_mask  = mask;
      trig_value = value;
      probe      = gen_probe(pk, 0);
      probe_en   = gen_en(ek, 0);
      trig_ext   = gen_ext(xk, 0);
      arm        = 1'b1;
      step();
      arm = 1'b0;
      chk({nm, " busy_after_arm"}, 64'(busy), 64'd1);
      chk({nm, " done_after_arm"}, 64'(done), 64'd0);
      for (int c = 1; c <= maxcyc && !seen; c++) begin
         probe    = gen_probe(pk, c);
         probe_en = gen_en(ek, c);
         trig_ext = gen_ext(xk, c);
         arm      = (c == rearm);
         if (probe_en) begin
            q_probe.push_back(probe);
            q_ext.push_back(trig_ext);
            q_cyc.push_back(c);
         end
         step();
         if (done) seen = 1'b1;
      end
      arm      = 1'b0;
      got_done = seen;
      ti       = model_trig(mode, mask, value);
      exp_end  = (ti < 0) ? -1 : ti + DP - PT;
      if (seen) begin
         chk({nm, " samples_at_done"}, 64'(q_probe.size()), 64'(exp_end));
         chk({nm, " triggered"}, 64'(triggered), 64'd1);
         chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
         if (ti >= 0) begin
            base = ti - PT;
            for (int k = 0; k <= DP; k++) begin
               if (k > 0) begin
                  rd_buf[k-1] = rd_data;
                  chk($sformatf("%s rd_data[%0d]", nm, k - 1), 64'(rd_data),
                      64'(q_probe[base+k-1]));
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
                  chk($sformatf("%s rd_ts[%0d]", nm, k - 1), 64'(rd_ts),
                      64'(q_cyc[base+k-1] - 1));
`else
                  chk($sformatf("%s rd_ts[%0d]", nm, k - 1), 64'(rd_ts), 64'd0);
`endif
               end
               if (k < DP) rd_addr = AW'(k);
               step();
            end
            chk({nm, " done_held"}, 64'(done), 64'd1);
         end
      end else begin
         chk({nm, " still_pending"},
             64'((exp_end < 0) || (exp_end > q_probe.size())), 64'd1);
         abort = 1'b1;
         step();
         abort = 1'b0;
         chk({nm, " idle_after_abort"}, 64'(busy), 64'd0);
      end
   endtask

   vec_t       tbl[$];
   logic       got;
   logic       seen;
   logic [1:0] rmode;
   logic [7:0] rmask;

   initial begin
      rst_n      = 1'b0;
      arm        = 1'b0;
      abort      = 1'b0;
      probe      = '0;
      probe_en   = 1'b0;
      trig_mode  = 2'b00;
      trig_mask  = '0;
      trig_value = '0;
      trig_ext   = 1'b0;
      rd_addr    = '0;
      repeat (3) step();
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset triggered", 64'(triggered), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset rd_data", 64'(rd_data), 64'd0);
      chk("reset rd_ts", 64'(rd_ts), 64'd0);
      rst_n = 1'b1;
      step();

      //           name           pk ek xk mode   mask   value  max  rearm e0     e4     e15
      tbl.push_back('{"level0A",    0, 0, 0, 2'b00, 8'hFF, 8'h0A, 100, -1, 8'h06, 8'h0A, 8'h15});
      tbl.push_back('{"prefill02",  0, 0, 0, 2'b00, 8'hFF, 8'h02, 400, -1, 8'hFE, 8'h02, 8'h0D});
      tbl.push_back('{"rising55",   2, 0, 0, 2'b01, 8'hFF, 8'h55, 100, -1, 8'h55, 8'h55, 8'h55});
      tbl.push_back('{"imm_toggle", 0, 1, 0, 2'b11, 8'h00, 8'h00, 100, -1, 8'h01, 8'h09, 8'h1F});
      tbl.push_back('{"ext20",      0, 0, 1, 2'b10, 8'hFF, 8'h00, 100, -1, 8'h10, 8'h14, 8'h1F});
      tbl.push_back('{"mask0F",     0, 0, 0, 2'b00, 8'h0F, 8'h07, 100, -1, 8'h03, 8'h07, 8'h12});
      tbl.push_back('{"rearm_busy", 0, 0, 0, 2'b00, 8'hFF, 8'h0A, 100,  6, 8'h06, 8'h0A, 8'h15});
      tbl.push_back('{"imm_cont",   0, 0, 0, 2'b11, 8'h00, 8'h00, 100, -1, 8'h01, 8'h05, 8'h10});

      for (int i = 0; i < tbl.size(); i++) begin
         capture(tbl[i].nm, tbl[i].pk, tbl[i].ek, tbl[i].xk, tbl[i].mode, tbl[i].mask,
                 tbl[i].value, tbl[i].maxcyc, tbl[i].rearm, got);
         chk({tbl[i].nm, " done_reached"}, 64'(got), 64'd1);
         if (got) begin
            chk({tbl[i].nm, " idx0"}, 64'(rd_buf[0]), 64'(tbl[i].e0));
            chk({tbl[i].nm, " idx4"}, 64'(rd_buf[4]), 64'(tbl[i].e4));
            chk({tbl[i].nm, " idx15"}, 64'(rd_buf[15]), 64'(tbl[i].e15));
         end
      end

      // Randomized captures against the list model.
      for (int r = 0; r < 24; r++) begin
         rmode = 2'($urandom_range(0, 3));
         rmask = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
         capture($sformatf("rand%0d", r), 1, 2, 2, rmode, rmask, 8'($urandom), 300,
                 $urandom_range(1, 40), got);
      end

      // Abort while in POST.
      trig_mode  = 2'b00;
      trig_mask  = 8'hFF;
      trig_value = 8'h0A;
      probe_en   = 1'b1;
      trig_ext   = 1'b0;
      probe      = 8'h00;
      arm        = 1'b1;
      step();
      arm  = 1'b0;
      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         probe = 8'(c);
         step();
         if (triggered) seen = 1'b1;
      end
      chk("abort trig_seen", 64'(seen), 64'd1);
      repeat (2) begin
         probe = probe + 8'd1;
         step();
      end
      chk("abort busy_before", 64'(busy), 64'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort triggered", 64'(triggered), 64'd0);

      // arm together with abort: stays idle.
      arm   = 1'b1;
      abort = 1'b1;
      step();
      arm   = 1'b0;
      abort = 1'b0;
      chk("arm_abort busy", 64'(busy), 64'd0);
      step();
      chk("arm_abort busy_later", 64'(busy), 64'd0);

      // Reset in the middle of a capture.
      trig_mode = 2'b11;
      arm       = 1'b1;
      step();
      arm = 1'b0;
      repeat (8) step();
      chk("midrst triggered_before", 64'(triggered), 64'd1);
      rst_n = 1'b0;
      step();
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst triggered", 64'(triggered), 64'd0);
      chk("midrst done", 64'(done), 64'd0);
      chk("midrst rd_data", 64'(rd_data), 64'd0);
      chk("midrst rd_ts", 64'(rd_ts), 64'd0);
      rst_n = 1'b1;
      step();

      // Fresh capture after reset.
      capture("post_reset", 0, 0, 0, 2'b00, 8'hFF, 8'h0A, 100, -1, got);
      chk("post_reset done_reached", 64'(got), 64'd1);
      if (got) chk("post_reset idx4", 64'(rd_buf[4]), 64'h0A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
